// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: active-low glyphs
// (bit order g..a) and the capture FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } cap_state_e;

  // Index width that stays legal for a single-digit display.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational inverse of the seg_pkg glyph table: active-low segments to a
// hex nibble, with valid low for any pattern that is not one of the 16 glyphs.
module seg7_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  // Glyph lookup
  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b1;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: begin
        nibble_o = 4'h0;
        valid_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed active-low seven-segment bus and rebuilds the displayed
// hex value digit by digit, flagging complete frames and bus errors.
module seven_seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  input  logic                    err_clear_in,
  output logic [4*NUM_DIGITS-1:0] val_out,
  output logic [NUM_DIGITS-1:0]   digit_valid_out,
  output logic                    frame_valid_out,
  output logic                    bad_pattern_out,
  output logic                    multi_anode_out
);

  localparam int unsigned         IDX_W      = idx_width(NUM_DIGITS);
  localparam logic [7:0]          SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ND_ZERO  = NUM_DIGITS'(0);
  localparam logic [NUM_DIGITS-1:0] ND_ONE   = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] ND_ONES  = ~ND_ZERO;

  logic [NUM_DIGITS-1:0]   an_sync_q [SYNC_STAGES];
  logic [6:0]              seg_sync_q [SYNC_STAGES];
  logic [NUM_DIGITS-1:0]   an_s, an_prev_q, act_s;
  logic [6:0]              seg_s, seg_prev_q;
  logic                    one_hot_s, multi_s, changed_s;
  logic [IDX_W-1:0]        idx_s;
  cap_state_e              state_q, state_d, nxt_s;
  logic [7:0]              cnt_q, cnt_d;
  logic                    take_s;
  logic                    smp_vld_q;
  logic [IDX_W-1:0]        smp_idx_q;
  logic [6:0]              smp_seg_q;
  logic [3:0]              dec_nib_s;
  logic                    dec_vld_s;
  logic [NUM_DIGITS-1:0]   sel_s, seen_new_s;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dv_q, dv_d, seen_q, seen_d;
  logic                    frame_q, frame_d, bad_q, bad_d, multi_q, multi_d, bad_set_s;

  // Input synchroniser plus one-cycle history; resets to an idle (blank) bus
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        an_sync_q[i]  <= ND_ONES;
        seg_sync_q[i] <= SEG_BLANK;
      end
      an_prev_q  <= ND_ONES;
      seg_prev_q <= SEG_BLANK;
    end else begin
      an_sync_q[0]  <= an_in;
      seg_sync_q[0] <= seg_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        an_sync_q[i]  <= an_sync_q[i-1];
        seg_sync_q[i] <= seg_sync_q[i-1];
      end
      an_prev_q  <= an_s;
      seg_prev_q <= seg_s;
    end
  end

  assign an_s      = an_sync_q[SYNC_STAGES-1];
  assign seg_s     = seg_sync_q[SYNC_STAGES-1];
  assign act_s     = ~an_s;
  assign one_hot_s = (act_s != ND_ZERO) && ((act_s & (act_s - ND_ONE)) == ND_ZERO);
  assign multi_s   = (act_s != ND_ZERO) && !one_hot_s;
  assign changed_s = (an_s != an_prev_q) || (seg_s != seg_prev_q);

  // Index of the active anode (only meaningful when one-hot)
  always_comb begin
    idx_s = IDX_W'(0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx_s = act_s[i] ? IDX_W'(i) : idx_s;
    end
  end

  // FSM state and settle counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; reaching the settle target from any counting path captures
  always_comb begin
    nxt_s = IDLE;
    cnt_d = 8'd0;
    case (state_q)
      IDLE: begin
        if (one_hot_s) begin
          nxt_s = SETTLE;
          cnt_d = 8'd1;
        end else begin
          nxt_s = IDLE;
          cnt_d = 8'd0;
        end
      end
      SETTLE: begin
        if (!one_hot_s) begin
          nxt_s = IDLE;
          cnt_d = 8'd0;
        end else if (changed_s) begin
          nxt_s = SETTLE;
          cnt_d = 8'd1;
        end else begin
          nxt_s = SETTLE;
          cnt_d = cnt_q + 8'd1;
        end
      end
      CAPTURED: begin
        if (!one_hot_s) begin
          nxt_s = IDLE;
          cnt_d = 8'd0;
        end else if (changed_s) begin
          nxt_s = SETTLE;
          cnt_d = 8'd1;
        end else begin
          nxt_s = CAPTURED;
          cnt_d = cnt_q;
        end
      end
      default: begin
        nxt_s = IDLE;
        cnt_d = 8'd0;
      end
    endcase
    state_d = ((nxt_s == SETTLE) && (cnt_d >= SETTLE_MAX)) ? CAPTURED : nxt_s;
  end

  // FSM output: sample strobe on entry to CAPTURED (a quiet hold does not re-sample)
  always_comb begin
    take_s = (state_d == CAPTURED) && ((state_q != CAPTURED) || changed_s);
  end

  // Sample register between the FSM and the digit file
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      smp_vld_q <= 1'b0;
      smp_idx_q <= IDX_W'(0);
      smp_seg_q <= SEG_BLANK;
    end else begin
      smp_vld_q <= take_s;
      smp_idx_q <= idx_s;
      smp_seg_q <= seg_s;
    end
  end

  seg7_to_nibble u_dec (
    .seg_i    (smp_seg_q),
    .nibble_o (dec_nib_s),
    .valid_o  (dec_vld_s)
  );

  // Digit file, seen mask, frame pulse and sticky error flags (set beats clear)
  always_comb begin
    val_d      = val_q;
    dv_d       = dv_q;
    sel_s      = ND_ZERO;
    seen_new_s = seen_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_s[i]          = smp_vld_q && (smp_idx_q == IDX_W'(i));
      val_d[4*i +: 4]   = (sel_s[i] && dec_vld_s) ? dec_nib_s : val_q[4*i +: 4];
      dv_d[i]           = sel_s[i] ? dec_vld_s : dv_q[i];
      seen_new_s[i]     = seen_q[i] | (sel_s[i] & dec_vld_s);
    end
    bad_set_s = smp_vld_q & ~dec_vld_s;
    frame_d   = smp_vld_q & dec_vld_s & (&seen_new_s);
    seen_d    = frame_d ? ND_ZERO : seen_new_s;
    bad_d     = bad_set_s | (bad_q & ~err_clear_in);
    multi_d   = multi_s | (multi_q & ~err_clear_in);
  end

  // Output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_q   <= {(4*NUM_DIGITS){1'b0}};
      dv_q    <= ND_ZERO;
      seen_q  <= ND_ZERO;
      frame_q <= 1'b0;
      bad_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      dv_q    <= dv_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      bad_q   <= bad_d;
      multi_q <= multi_d;
    end
  end

  assign val_out         = val_q;
  assign digit_valid_out = dv_q;
  assign frame_valid_out = frame_q;
  assign bad_pattern_out = bad_q;
  assign multi_anode_out = multi_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: a dwell-based reference model predicts
// digit captures and frames; a monitor pops expected frames on each frame pulse.
module tb_seven_seg_capture;
  import seg_pkg::*;

  localparam int ND = 8;
  localparam int N_SETTLE = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [7:0]  an_in = 8'hFF;
  logic [6:0]  seg_in = 7'h7F;
  logic        err_clear_in = 1'b0;
  logic [31:0] val_out;
  logic [7:0]  digit_valid_out;
  logic        frame_valid_out, bad_pattern_out, multi_anode_out;

  always #5 clk_in = ~clk_in;

  seven_seg_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(N_SETTLE), .SYNC_STAGES(2)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .an_in           (an_in),
    .seg_in          (seg_in),
    .err_clear_in    (err_clear_in),
    .val_out         (val_out),
    .digit_valid_out (digit_valid_out),
    .frame_valid_out (frame_valid_out),
    .bad_pattern_out (bad_pattern_out),
    .multi_anode_out (multi_anode_out)
  );

  // Glyphs written out from the display table (g..a, active-low)
  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int frames_pushed = 0;

  // Reference model state
  logic [31:0] m_val;
  logic [7:0]  m_dv, m_seen;
  logic        m_bad, m_multi;
  logic [7:0]  p_an;
  logic [6:0]  p_seg;
  int          p_dwell;
  bit          p_done;
  logic [39:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (glyph[k] == s) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_val = 32'h0; m_dv = 8'h0; m_seen = 8'h0; m_bad = 1'b0; m_multi = 1'b0;
    p_an = 8'hFF; p_seg = 7'h7F; p_dwell = 0; p_done = 1'b0;
    exp_q.delete();
  endtask

  // A pattern held for at least N_SETTLE cycles since it last changed is captured once
  task automatic model_step(input logic [7:0] a, input logic [6:0] s, input int d);
    int ones, idx, nib;
    ones = $countones(~a);
    if (a == p_an && s == p_seg) p_dwell += d;
    else begin
      p_an = a; p_seg = s; p_dwell = d; p_done = 1'b0;
    end
    if (ones > 1) m_multi = 1'b1;
    if (ones == 1 && !p_done && p_dwell >= N_SETTLE) begin
      p_done = 1'b1;
      idx = 0;
      for (int k = 0; k < ND; k++) if (!a[k]) idx = k;
      nib = decode(s);
      if (nib >= 0) begin
        m_val[idx*4 +: 4] = 4'(nib);
        m_dv[idx] = 1'b1;
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
          exp_q.push_back({m_val, m_dv});
          frames_pushed++;
          m_seen = 8'h0;
        end
      end else begin
        m_dv[idx] = 1'b0;
        m_bad = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [6:0] s, input int d);
    an_in = a; seg_in = s;
    model_step(a, s, d);
    cyc(d);
  endtask

  task automatic quiesce();
    step(8'hFF, 7'h7F, 10);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_val"}, val_out, m_val);
    chk({tag, "_dv"}, digit_valid_out, m_dv);
    chk({tag, "_bad"}, bad_pattern_out, m_bad);
    chk({tag, "_multi"}, multi_anode_out, m_multi);
    chk({tag, "_frame"}, frame_valid_out, 1'b0);
  endtask

  task automatic err_clear();
    err_clear_in = 1'b1; cyc(1); err_clear_in = 1'b0; cyc(1);
    m_bad = 1'b0; m_multi = 1'b0;
  endtask

  task automatic monitor();
    logic [39:0] e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && frame_valid_out) begin
        frames_seen++;
        if (exp_q.size() == 0) chk("frame_unexpected", frame_valid_out, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("frame_val", val_out, e[39:8]);
          chk("frame_dv", digit_valid_out, e[7:0]);
        end
      end
    end
  endtask

  task automatic random_batch(input int n);
    for (int s = 0; s < n; s++) begin
      int r, d, a, b;
      logic [7:0] an;
      logic [6:0] sg;
      r  = $urandom_range(0, 99);
      d  = $urandom_range(0, 7);
      sg = (r < 85) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      if (r >= 90 && r < 96) begin
        a  = $urandom_range(0, 7);
        b  = (a + $urandom_range(1, 7)) % 8;
        an = ~((8'd1 << a) | (8'd1 << b));
      end else if (r >= 96) an = 8'hFF;
      else an = ~(8'd1 << d);
      step(an, sg, $urandom_range(1, 8));
    end
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  old_nib;
    model_reset();
    fork
      monitor();
    join_none

    // Reset behaviour and first capture latency
    an_in = 8'hFE; seg_in = glyph[1];
    cyc(3);
    check_all("in_reset");
    rst_n_in = 1'b1;
    model_step(8'hFE, glyph[1], 7);
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      chk("rst_rel_val", val_out, (k < 7) ? 32'h0 : m_val);
      chk("rst_rel_dv", digit_valid_out, (k < 7) ? 8'h0 : m_dv);
      chk("rst_rel_frame", frame_valid_out, 1'b0);
    end

    // Two full scans of 0xDEADBEEF
    word = 32'hDEADBEEF;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < ND; i++) step(~(8'd1 << i), glyph[word[i*4 +: 4]], 10);
    quiesce();
    check_all("scan");
    chk("scan_value", val_out, 32'hDEADBEEF);
    chk("scan_frames", frames_seen, 2);

    // Short dwell then minimum dwell on digit 2
    step(8'hFB, glyph[7], 3);
    quiesce();
    check_all("dwell3");
    step(8'hFB, glyph[7], 4);
    quiesce();
    check_all("dwell4");
    chk("dwell4_digit2", val_out[11:8], 4'h7);

    // Blank glyph on digit 5, then clear
    step(8'hDF, 7'h7F, 10);
    quiesce();
    check_all("bad_glyph");
    err_clear();
    check_all("bad_cleared");

    // Ghosting, with a clear coinciding with the ongoing error
    an_in = 8'hFC; seg_in = glyph[3];
    model_step(8'hFC, glyph[3], 10);
    cyc(5); err_clear_in = 1'b1; cyc(1); err_clear_in = 1'b0; cyc(4);
    chk("ghost_state_idle", dut.state_q, IDLE);
    quiesce();
    check_all("ghost");
    err_clear();
    check_all("ghost_cleared");

    // Live update latency on digit 0
    step(8'hFE, glyph[5], 10);
    old_nib = m_val[3:0];
    seg_in = glyph[8];
    model_step(8'hFE, glyph[8], 7);
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      chk("live_val", val_out[3:0], (k < 7) ? old_nib : m_val[3:0]);
    end
    quiesce();
    check_all("live");

    // Randomised traffic
    for (int b = 0; b < 4; b++) begin
      random_batch(30);
      quiesce();
      check_all("rand");
      err_clear();
      check_all("rand_cleared");
    end

    // Reset asserted mid-settle
    an_in = 8'hF7; seg_in = glyph[2];
    cyc(4);
    #2 rst_n_in = 1'b0;
    #1;
    model_reset();
    chk("midrst_val", val_out, 32'h0);
    chk("midrst_dv", digit_valid_out, 8'h0);
    chk("midrst_bad", bad_pattern_out, 1'b0);
    chk("midrst_multi", multi_anode_out, 1'b0);
    an_in = 8'hFF; seg_in = 7'h7F;
    cyc(2);
    rst_n_in = 1'b1;
    step(8'hFE, glyph[9], 6);
    quiesce();
    check_all("post_reset");

    chk("frame_count", frames_seen, frames_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
